mem_bus_unit: RTL and testbench
===============================

MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 32: bus/effective address width.
- TIMEOUT, 255: maximum ACCESS cycles without ack before a bus error (1..65535).
- LLBIT_EN, 1: 1 = LL/SC supported; 0 = SC always fails, llbit_o tied to 0.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset.
- req_i, in, 1: memory op valid from MEM stage.
- op_i, in, 4: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC; others are no-op.
- addr_i, in, ADDR_W: effective address.
- wdata_i, in, 32: store data (reg2).
- flush_i, in, 1: pipeline flush.
- llbit_clear_i, in, 1: clear LL bit (eret/exception).
- stall_req_o, out, 1: stall request to pipeline control.
- done_o, out, 1: one-cycle completion pulse.
- rdata_o, out, 32: load result or SC status.
- exc_o, out, 1: exception valid, qualified by done_o.
- exc_code_o, out, 2: 1 load misaligned, 2 store misaligned, 3 bus timeout.
- badvaddr_o, out, ADDR_W: faulting address.
- llbit_o, out, 1: current LL bit.
- bus_cyc_o, out, 1; bus_stb_o, out, 1; bus_we_o, out, 1; bus_sel_o, out, 4; bus_adr_o, out, ADDR_W; bus_dat_o, out, 32: bus master outputs.
- bus_dat_i, in, 32; bus_ack_i, in, 1: bus master inputs.
REQ-003 One clock (clk); rst is synchronous, active-high; all state changes occur on the rising edge of clk.

Function
REQ-004 FSM states: IDLE, ACCESS, DONE, all registered.
REQ-005 IDLE transitions when req_i=1 and op_i is valid:
- Misaligned access (halfword with addr[0]=1, word/LL/SC with addr[1:0]!=0) -> DONE, exc_o=1, code 1 (loads/LL) or 2 (stores/SC), badvaddr_o=addr_i.
- SC with LL bit 0 -> DONE, rdata_o=0, no bus cycle.
- Otherwise -> ACCESS, with address/op/data latched into internal registers.
REQ-006 IDLE with req_i=0 or an invalid op: remain in IDLE; stall_req_o=0.
REQ-007 ACCESS: bus_cyc_o=bus_stb_o=1. bus_adr_o={addr[ADDR_W-1:2],2'b00}. bus_we_o=1 for SB/SH/SW/SC.
REQ-008 Big-endian byte lanes:
- Byte offsets 0/1/2/3 -> sel 1000/0100/0010/0001.
- Half offsets 0/2 -> sel 1100/0011.
- Word -> sel 1111.
- bus_dat_o: byte replicated x4, half replicated x2, word as is.
REQ-009 Load extraction from bus_dat_i: selected lane, sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW/LL. Result is captured into rdata_o on the ack cycle.
REQ-010 ACCESS with bus_ack_i=1 -> DONE; bus outputs are deasserted the next cycle. Successful SC sets rdata_o=1. Stores leave rdata_o=0.
REQ-011 Timeout counter (16 bits):
- Cleared on entry to ACCESS; increments every ACCESS cycle without ack.
- When it reaches TIMEOUT-1 with no ack -> DONE, exc_o=1, code 3, badvaddr_o=latched address; bus deasserted.
- Ack and timeout in the same cycle: ack wins.
REQ-012 DONE: done_o=1 for exactly one cycle, stall_req_o=0, then -> IDLE unconditionally. req_i is ignored in DONE, so back-to-back ops incur a minimum latency of 3 cycles (IDLE->ACCESS->DONE with 1-cycle ack).
REQ-013 stall_req_o = (IDLE and req_i and valid op) or ACCESS; it is combinational from state and inputs.
REQ-014 rdata_o, exc_o, exc_code_o and badvaddr_o hold their values from DONE until the next DONE.
REQ-015 flush_i=1 in any state -> IDLE next cycle. Bus is deasserted immediately (combinational gating of cyc/stb). No done_o, no LL bit update, and a late ack is ignored.
REQ-016 LL bit priority (highest first): rst, llbit_clear_i, SC success clear, LL completion set. LL sets on its ack cycle; SC clears on its ack cycle.
REQ-017 LLBIT_EN=0: LL behaves as LW; SC takes the REQ-005 failure path.

Reset
REQ-018 With rst=1 on an edge:
- State=IDLE; counter=0; LL bit=0.
- rdata_o=0, exc_o=0, exc_code_o=0, badvaddr_o=0.
- All bus outputs 0; done_o=0.
- stall_req_o=0 while rst is high.
REQ-019 rst asserted mid-ACCESS aborts the bus cycle (cyc=0 next cycle) with no done_o.

Verification
REQ-020 LB at addr 0x103, bus_dat_i=0x11223380, ack after 2 cycles -> sel=0001, adr=0x100, rdata_o=0xFFFFFF80, done_o one pulse, stall released in the DONE cycle.
REQ-021 SH at 0x202 with wdata_i=0xAAAA1234 -> sel=0011, we=1, bus_dat_o=0x12341234; LW at 0x201 -> no bus cycle, done_o with exc_code_o=1, badvaddr_o=0x201.
REQ-022 LL at 0x40 (ack), SC at 0x40 -> write occurs, rdata_o=1, llbit_o=0. A second SC -> no bus cycle, rdata_o=0.
REQ-023 LL, then llbit_clear_i pulse, then SC -> SC fails, rdata_o=0.
REQ-024 TIMEOUT=4, SW with no ack -> cyc high for 4 cycles, then done_o with exc_code_o=3.
REQ-025 flush_i during ACCESS, with ack arriving in the next cycle -> cyc drops, no done_o, LL bit unchanged, FSM in IDLE.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Memory access unit: drives a single-beat bus master for loads/stores/LL/SC,
// with big-endian lane steering, alignment checks, bus timeout and an LL bit.
module mem_bus_unit #(
  parameter int ADDR_W   = 32,
  parameter int TIMEOUT  = 255,
  parameter bit LLBIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              llbit_clear_i,
  output logic              stall_req_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              exc_o,
  output logic [1:0]        exc_code_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              llbit_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_adr_o,
  output logic [31:0]       bus_dat_o,
  input  logic [31:0]       bus_dat_i,
  input  logic              bus_ack_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LW = 4'd4, OP_SB  = 4'd5, OP_SH = 4'd6, OP_SW  = 4'd7,
                         OP_LL = 4'd8, OP_SC  = 4'd9;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, bad_q, bad_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              exc_q, exc_d, ll_q, ll_d, ll_set, ll_sc_clr;
  logic [1:0]        code_q, code_d;

  logic        op_valid, misal, st_in, st_q, bus_act;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, st_dat;
  logic [3:0]  sel;

  // Request decode on the incoming op
  always_comb begin
    op_valid = (op_i <= OP_SC);
    st_in    = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW) || (op_i == OP_SC);
    case (op_i)
      OP_LH, OP_LHU, OP_SH:       misal = addr_i[0];
      OP_LW, OP_SW, OP_LL, OP_SC: misal = (addr_i[1:0] != 2'b00);
      default:                    misal = 1'b0;
    endcase
  end

  // Lane steering on the latched op; byte offset 0 is the MSB lane
  always_comb begin
    st_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW) || (op_q == OP_SC);
    case (addr_q[1:0])
      2'd0:    lane_b = bus_dat_i[31:24];
      2'd1:    lane_b = bus_dat_i[23:16];
      2'd2:    lane_b = bus_dat_i[15:8];
      default: lane_b = bus_dat_i[7:0];
    endcase
    lane_h = addr_q[1] ? bus_dat_i[15:0] : bus_dat_i[31:16];
    case (op_q)
      OP_LB, OP_LBU, OP_SB: begin
        sel    = 4'b1000 >> addr_q[1:0];
        st_dat = {4{wdata_q[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel    = addr_q[1] ? 4'b0011 : 4'b1100;
        st_dat = {2{wdata_q[15:0]}};
      end
      default: begin
        sel    = 4'b1111;
        st_dat = wdata_q;
      end
    endcase
    case (op_q)
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'd0, lane_b};
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'd0, lane_h};
      default: load_val = bus_dat_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    exc_d     = exc_q;
    code_d    = code_q;
    bad_d     = bad_q;
    ll_set    = 1'b0;
    ll_sc_clr = 1'b0;
    case (state_q)
      IDLE: if (req_i && op_valid) begin
        if (misal) begin
          state_d = DONE;
          rdata_d = '0;
          exc_d   = 1'b1;
          code_d  = st_in ? 2'd2 : 2'd1;
          bad_d   = addr_i;
        end else if (op_i == OP_SC && !ll_q) begin
          state_d = DONE;
          rdata_d = '0;
          exc_d   = 1'b0;
          code_d  = 2'd0;
        end else begin
          state_d = ACCESS;
          addr_d  = addr_i;
          op_d    = op_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        // ack takes priority over an expiring timeout
        if (bus_ack_i) begin
          state_d   = DONE;
          rdata_d   = st_q ? {31'd0, op_q == OP_SC} : load_val;
          exc_d     = 1'b0;
          code_d    = 2'd0;
          ll_set    = (op_q == OP_LL);
          ll_sc_clr = (op_q == OP_SC);
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          rdata_d = '0;
          exc_d   = 1'b1;
          code_d  = 2'd3;
          bad_d   = addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush discards the op in flight, including any completion it would record
    if (flush_i) begin
      state_d   = IDLE;
      rdata_d   = rdata_q;
      exc_d     = exc_q;
      code_d    = code_q;
      bad_d     = bad_q;
      ll_set    = 1'b0;
      ll_sc_clr = 1'b0;
    end
    if (llbit_clear_i || ll_sc_clr) ll_d = 1'b0;
    else if (ll_set)                ll_d = LLBIT_EN;
    else                            ll_d = ll_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
      ll_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
      ll_q    <= ll_d;
    end
  end

  assign bus_act     = (state_q == ACCESS) && !flush_i;
  assign bus_cyc_o   = bus_act;
  assign bus_stb_o   = bus_act;
  assign bus_we_o    = bus_act && st_q;
  assign bus_sel_o   = bus_act ? sel : 4'b0000;
  assign bus_adr_o   = bus_act ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_dat_o   = bus_act ? st_dat : 32'd0;
  assign stall_req_o = !rst && (((state_q == IDLE) && req_i && op_valid) || (state_q == ACCESS));
  assign done_o      = (state_q == DONE) && !flush_i;
  assign rdata_o     = rdata_q;
  assign exc_o       = exc_q;
  assign exc_code_o  = code_q;
  assign badvaddr_o  = bad_q;
  assign llbit_o     = ll_q;
endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: results are checked by a scoreboard monitor on done_o,
// bus-side behaviour is checked inline by the stimulus.
module tb_mem_bus_unit;
  logic        clk, rst, req_i, flush_i, llbit_clear_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_req_o, done_o, exc_o, llbit_o;
  logic [31:0] rdata_o, badvaddr_o;
  logic [1:0]  exc_code_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;

  mem_bus_unit #(.ADDR_W(32), .TIMEOUT(4), .LLBIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .llbit_clear_i(llbit_clear_i), .stall_req_o(stall_req_o),
    .done_o(done_o), .rdata_o(rdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
    .badvaddr_o(badvaddr_o), .llbit_o(llbit_o), .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i));

  localparam logic [3:0] LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7, LL = 8, SC = 9;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  code;
    logic [31:0] bad;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0, n_tot = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done_o) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_done: got done_o=1 required no pending op");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rdata", rdata_o, mon_e.rdata);
        chk("exc", exc_o, mon_e.exc);
        chk("exc_code", exc_code_o, mon_e.code);
        if (mon_e.exc) chk("badvaddr", badvaddr_o, mon_e.bad);
      end
    end
  end

  // Called at posedge+1 with the FSM in IDLE; returns at posedge+1 back in IDLE.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] bdat, input int ack_at, input int ecyc,
                       input logic [3:0] esel, input logic [31:0] edat, input logic [31:0] erd,
                       input logic [1:0] ecode, input logic [31:0] ebad);
    exp_t e;
    int   n;
    logic st;
    st = (op == SB) || (op == SH) || (op == SW) || (op == SC);
    e.rdata = erd; e.exc = (ecode != 2'd0); e.code = ecode; e.bad = ebad;
    exp_q.push_back(e);
    req_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; bus_dat_i = bdat;
    @(negedge clk);
    chk("stall_on_req", stall_req_o, 1);
    @(posedge clk); #1;
    req_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      bus_ack_i = (k == ack_at);
      @(negedge clk);
      if (!bus_cyc_o) break;
      n++;
      if (k == 0) begin
        chk("bus_sel", bus_sel_o, esel);
        chk("bus_adr", bus_adr_o, {a[31:2], 2'b00});
        chk("bus_we", bus_we_o, st);
        chk("bus_stb", bus_stb_o, 1);
        chk("stall_in_access", stall_req_o, 1);
        if (st) chk("bus_dat", bus_dat_o, edat);
      end
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
    end
    bus_ack_i = 1'b0;
    chk("bus_cycles", n, ecyc);
    chk("done_pulse", done_o, 1);
    chk("stall_in_done", stall_req_o, 0);
    @(posedge clk); #1;
    chk("done_single", done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0; flush_i = 1'b0;
    llbit_clear_i = 1'b0; bus_dat_i = '0; bus_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    req_i = 1'b1; op_i = LW;
    @(negedge clk);
    chk("rst_stall", stall_req_o, 0);
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_sel", bus_sel_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_exc", {exc_o, exc_code_o}, 0);
    chk("rst_bad", badvaddr_o, 0);
    chk("rst_llbit", llbit_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_i = 1'b0;
    @(posedge clk); #1;

    // op, addr, wdata, bus_dat_i, ack_at, cycles, sel, store data, rdata, code, badvaddr
    do_op(LB,  32'h103, 32'h0,        32'h11223380, 1,  2, 4'b0001, 32'h0,        32'hFFFFFF80, 2'd0, 32'h0);
    do_op(LBU, 32'h101, 32'h0,        32'h11A23380, 0,  1, 4'b0100, 32'h0,        32'h000000A2, 2'd0, 32'h0);
    do_op(LH,  32'h102, 32'h0,        32'h1122F380, 0,  1, 4'b0011, 32'h0,        32'hFFFFF380, 2'd0, 32'h0);
    do_op(LHU, 32'h100, 32'h0,        32'h8122F380, 0,  1, 4'b1100, 32'h0,        32'h00008122, 2'd0, 32'h0);
    do_op(LW,  32'h10C, 32'h0,        32'hDEADBEEF, 0,  1, 4'b1111, 32'h0,        32'hDEADBEEF, 2'd0, 32'h0);
    do_op(SH,  32'h202, 32'hAAAA1234, 32'h0,        0,  1, 4'b0011, 32'h12341234, 32'h0,        2'd0, 32'h0);
    do_op(SB,  32'h201, 32'h000000C5, 32'h0,        0,  1, 4'b0100, 32'hC5C5C5C5, 32'h0,        2'd0, 32'h0);
    do_op(LW,  32'h201, 32'h0,        32'h0,        -1, 0, 4'b0000, 32'h0,        32'h0,        2'd1, 32'h201);
    do_op(SW,  32'h302, 32'h0,        32'h0,        -1, 0, 4'b0000, 32'h0,        32'h0,        2'd2, 32'h302);
    do_op(LH,  32'h101, 32'h0,        32'h0,        -1, 0, 4'b0000, 32'h0,        32'h0,        2'd1, 32'h101);

    // LL / SC pair, then a second SC with the LL bit already consumed
    do_op(LL,  32'h40,  32'h0,        32'h12345678, 0,  1, 4'b1111, 32'h0,        32'h12345678, 2'd0, 32'h0);
    chk("llbit_after_ll", llbit_o, 1);
    do_op(SC,  32'h40,  32'h00000055, 32'h0,        0,  1, 4'b1111, 32'h00000055, 32'h1,        2'd0, 32'h0);
    chk("llbit_after_sc", llbit_o, 0);
    do_op(SC,  32'h40,  32'h00000055, 32'h0,        -1, 0, 4'b0000, 32'h0,        32'h0,        2'd0, 32'h0);
    do_op(SC,  32'h42,  32'h0,        32'h0,        -1, 0, 4'b0000, 32'h0,        32'h0,        2'd2, 32'h42);

    // LL bit cleared externally makes the following SC fail
    do_op(LL,  32'h44,  32'h0,        32'hCAFEF00D, 0,  1, 4'b1111, 32'h0,        32'hCAFEF00D, 2'd0, 32'h0);
    llbit_clear_i = 1'b1;
    @(posedge clk); #1;
    llbit_clear_i = 1'b0;
    @(negedge clk);
    chk("llbit_cleared", llbit_o, 0);
    @(posedge clk); #1;
    do_op(SC,  32'h44,  32'h0,        32'h0,        -1, 0, 4'b0000, 32'h0,        32'h0,        2'd0, 32'h0);

    // Bus timeout with TIMEOUT=4
    do_op(SW,  32'h500, 32'h13579BDF, 32'h0,        -1, 4, 4'b1111, 32'h13579BDF, 32'h0,        2'd3, 32'h500);

    // Flush during ACCESS with a late ack
    do_op(LL,  32'h48,  32'h0,        32'h0BADBEEF, 0,  1, 4'b1111, 32'h0,        32'h0BADBEEF, 2'd0, 32'h0);
    req_i = 1'b1; op_i = LL; addr_i = 32'h80;
    @(posedge clk); #1;
    req_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    chk("flush_cyc_gated", bus_cyc_o, 0);
    chk("flush_no_done", done_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'h55555555;
    @(negedge clk);
    chk("flush_idle_cyc", bus_cyc_o, 0);
    chk("flush_idle_stall", stall_req_o, 0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("flush_late_ack_done", done_o, 0);
    chk("flush_llbit_kept", llbit_o, 1);
    chk("flush_rdata_kept", rdata_o, 32'h0BADBEEF);
    @(posedge clk); #1;

    // Reset mid-ACCESS aborts the bus cycle
    req_i = 1'b1; op_i = LW; addr_i = 32'h90;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_cyc", bus_cyc_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_cyc", bus_cyc_o, 0);
    chk("rst_abort_done", done_o, 0);
    chk("rst_abort_llbit", llbit_o, 0);
    @(posedge clk); #1;
    do_op(LW,  32'h10C, 32'h0,        32'h01020304, 0,  1, 4'b1111, 32'h0,        32'h01020304, 2'd0, 32'h0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
